// File: rtl/regbus_pkg.sv
// Shared types and defaults for the register-bus initiator.
package regbus_pkg;

  localparam int          BUS_ADDR_W      = 32;
  localparam int          BUS_DATA_W      = 32;
  localparam int          DEF_TIMEOUT_CYC = 16;
  localparam logic [31:0] DEF_ERR_DATA    = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic                    write;
    logic [BUS_ADDR_W-1:0]   addr;
    logic [BUS_DATA_W-1:0]   wdata;
    logic [BUS_DATA_W/8-1:0] wstrb;
  } cmd_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/regbus_if.sv
// Register-block bus: one initiator drives strobes/address/data, one block answers with READY/DATA_RD.
interface regbus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   addr;
  logic                we;
  logic                re;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;

  modport master (output addr, we, re, wdata, wstrb, input rdata, ready);
  modport slave  (input addr, we, re, wdata, wstrb, output rdata, ready);

endinterface

// File: rtl/regbus_sat_counter.sv
// Saturating event counter with synchronous clear.
module regbus_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // NOTE: default assignment first so every path writes count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/regbus_initiator.sv
// Single-outstanding register-bus initiator: command in, one bus access, response out.
module regbus_initiator
  import regbus_pkg::*;
#(
  parameter int                ADDR_W      = BUS_ADDR_W,
  parameter int                DATA_W      = BUS_DATA_W,
  parameter int                TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(DEF_ERR_DATA)
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  regbus_if.master            bus,
  output logic [15:0]         txn_count,
  output logic [15:0]         err_count
);

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  state_t              state_q;
  cmd_t                cmd_q;
  logic                we_q;
  logic                re_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                cmd_fire;
  logic                rsp_fire;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign rsp_fire = rsp_valid_q && rsp_ready;

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            cmd_ready_q <= 1'b0;
            if (is_misaligned(cmd_addr[1:0])) begin
              // Rejected without touching the bus; bus address/data keep their last value.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= cmd_write ? '0 : ERR_DATA;
            end else begin
              state_q     <= ACCESS;
              cmd_q.write <= cmd_write;
              cmd_q.addr  <= BUS_ADDR_W'(cmd_addr);
              cmd_q.wdata <= BUS_DATA_W'(cmd_wdata);
              cmd_q.wstrb <= (BUS_DATA_W/8)'(cmd_wstrb);
              we_q        <= cmd_write;
              re_q        <= !cmd_write;
              wait_q      <= '0;
            end
          end
        end
        ACCESS: begin
          // READY on the last allowed cycle still counts as success.
          if (bus.ready || (wait_q == WAIT_LAST)) begin
            state_q     <= RESP;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !bus.ready;
            rsp_rdata_q <= cmd_q.write ? '0 : (bus.ready ? bus.rdata : ERR_DATA);
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_fire) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  assign bus.addr  = cmd_q.addr[ADDR_W-1:0];
  assign bus.wdata = cmd_q.wdata[DATA_W-1:0];
  assign bus.wstrb = cmd_q.wstrb[DATA_W/8-1:0];
  assign bus.we    = we_q;
  assign bus.re    = re_q;

  regbus_sat_counter #(.WIDTH(16)) u_txn_cnt (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr_i   (1'b0),
    .inc_i   (rsp_fire),
    .count_o (txn_count)
  );

  regbus_sat_counter #(.WIDTH(16)) u_err_cnt (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr_i   (1'b0),
    .inc_i   (rsp_fire && rsp_err_q),
    .count_o (err_count)
  );

endmodule
